// File: rtl/pb_irq_controller.sv
// KCPSM6 interrupt controller: edge-latched sources, mask/enable gating, priority vector
// and an ASSERT/SERVICE handshake that waits for an EOI before raising the next request.
module pb_irq_controller #(
  parameter int          NUM_SRC   = 8,
  parameter logic [7:0]  BASE_PORT = 8'h40
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [7:0]         port_id,
  input  logic               write_strobe,
  input  logic [7:0]         out_port,
  input  logic               read_strobe,
  output logic [7:0]         rd_data,
  output logic               rd_hit,
  output logic               interrupt,
  input  logic               interrupt_ack
);

  typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_SERVICE} state_t;

  state_t             state, next_state;
  logic [NUM_SRC-1:0] sync1, sync2, sync3;
  logic [NUM_SRC-1:0] edge_det, pending, mask, active;
  logic [NUM_SRC-1:0] ack_onehot, pend_clr, pend_next;
  logic [2:0]         lowest_id, vec_id;
  logic               ctrl_en, vec_valid;
  logic               wr_hit, wr_pend, wr_mask, wr_vec, wr_ctrl;
  logic               take_ack, eoi, int_next;
  logic [7:0]         rd_mux;

  // Read strobe carries no side effects; the read path runs every cycle.
  logic unused_inputs;
  assign unused_inputs = ^{read_strobe, out_port};

  assign wr_hit  = write_strobe && (port_id[7:2] == BASE_PORT[7:2]);
  assign wr_pend = wr_hit && (port_id[1:0] == 2'd0);
  assign wr_mask = wr_hit && (port_id[1:0] == 2'd1);
  assign wr_vec  = wr_hit && (port_id[1:0] == 2'd2);
  assign wr_ctrl = wr_hit && (port_id[1:0] == 2'd3);

  // NOTE: sequential state uses non-blocking assignments and an asynchronous reset so every
  // flop clears the moment reset_n falls, independent of the clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign edge_det = sync2 & ~sync3;
  assign active   = pending & mask;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    lowest_id  = '0;
    ack_onehot = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        lowest_id     = 3'(i);
        ack_onehot    = '0;
        ack_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (ctrl_en && (|active)) next_state = ST_ASSERT;
      ST_ASSERT: begin
        if (!ctrl_en || !(|active)) next_state = ST_IDLE;
        else if (interrupt_ack)     next_state = ST_SERVICE;
      end
      ST_SERVICE: if (wr_vec) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    take_ack = 1'b0;
    eoi      = 1'b0;
    int_next = 1'b0;
    case (state)
      ST_ASSERT: begin
        take_ack = (next_state == ST_SERVICE);
        int_next = (next_state == ST_ASSERT);
      end
      ST_SERVICE: eoi = (next_state == ST_IDLE);
      default: ;
    endcase
  end

  // A new edge outranks a clear landing on the same bit in the same cycle.
  assign pend_clr  = (wr_pend ? out_port[NUM_SRC-1:0] : '0) | (take_ack ? ack_onehot : '0);
  assign pend_next = (pending & ~pend_clr) | edge_det;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending   <= '0;
      mask      <= '0;
      ctrl_en   <= 1'b0;
      vec_valid <= 1'b0;
      vec_id    <= '0;
      interrupt <= 1'b0;
    end else begin
      pending   <= pend_next;
      interrupt <= int_next;
      if (wr_mask) mask    <= out_port[NUM_SRC-1:0];
      if (wr_ctrl) ctrl_en <= out_port[0];
      if (take_ack) begin
        vec_valid <= 1'b1;
        vec_id    <= lowest_id;
      end else if (eoi) begin
        vec_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (port_id[1:0])
      2'd0:    rd_mux[NUM_SRC-1:0] = pending;
      2'd1:    rd_mux[NUM_SRC-1:0] = mask;
      2'd2:    rd_mux = {vec_valid, 4'b0000, vec_id};
      default: rd_mux = {7'b0000000, ctrl_en};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
      rd_hit  <= 1'b0;
    end else begin
      rd_data <= rd_mux;
      rd_hit  <= (port_id[7:2] == BASE_PORT[7:2]);
    end
  end

endmodule

// File: tb/tb_pb_irq_controller.sv
// Directed and randomized checks of pb_irq_controller against a transaction-level model
// of the register file and the ack/EOI handshake.
module tb_pb_irq_controller;

  localparam logic [7:0] BASE = 8'h40;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] irq_src;
  logic [7:0] port_id;
  logic       write_strobe;
  logic [7:0] out_port;
  logic       read_strobe;
  logic [7:0] rd_data;
  logic       rd_hit;
  logic       interrupt;
  logic       interrupt_ack;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] m_pend, m_mask, ev, w, act;
  logic       m_en;
  logic [7:0] rdv;
  logic       rdh;
  int         idx;

  pb_irq_controller #(.NUM_SRC(8), .BASE_PORT(BASE)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .irq_src       (irq_src),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .out_port      (out_port),
    .read_strobe   (read_strobe),
    .rd_data       (rd_data),
    .rd_hit        (rd_hit),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [7:0] data);
    @(negedge clk);
    port_id      = BASE + off;
    out_port     = data;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
    port_id      = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] off, output logic [7:0] data, output logic hit);
    @(negedge clk);
    port_id     = BASE + off;
    read_strobe = 1'b1;
    @(negedge clk);
    data        = rd_data;
    hit         = rd_hit;
    read_strobe = 1'b0;
    port_id     = 8'h00;
  endtask

  task automatic chk_reg(input string tag, input logic [7:0] off, input logic [7:0] exp);
    logic [7:0] d;
    logic       h;
    bus_read(off, d, h);
    check(tag, d, exp);
  endtask

  task automatic pulse(input logic [7:0] m);
    @(negedge clk);
    irq_src = irq_src | m;
    repeat (3) @(negedge clk);
    irq_src = irq_src & ~m;
    repeat (4) @(negedge clk);
  endtask

  task automatic ack();
    @(negedge clk);
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
  endtask

  task automatic wait_irq(input string tag, input logic exp, input int budget);
    int n = 0;
    while (interrupt !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {7'b0, interrupt}, {7'b0, exp});
  endtask

  initial begin
    reset_n = 1'b0; irq_src = '0; port_id = '0; write_strobe = 1'b0;
    out_port = '0; read_strobe = 1'b0; interrupt_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    check("rst_irq", {7'b0, interrupt}, 8'h00);
    check("rst_hit", {7'b0, rd_hit}, 8'h00);
    check("rst_rdata", rd_data, 8'h00);
    chk_reg("rst_pending", 8'd0, 8'h00);
    chk_reg("rst_mask", 8'd1, 8'h00);
    chk_reg("rst_vector", 8'd2, 8'h00);
    chk_reg("rst_ctrl", 8'd3, 8'h00);

    // Single source: exact capture latency and interrupt timing.
    bus_write(8'd1, 8'h01);
    bus_write(8'd3, 8'h01);
    @(negedge clk);
    port_id    = BASE;
    irq_src[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("t1_pend_before", rd_data, 8'h00);
    @(negedge clk);
    check("t1_pend_3clk", rd_data, 8'h01);
    check("t1_irq_early", {7'b0, interrupt}, 8'h00);
    @(negedge clk);
    check("t1_irq", {7'b0, interrupt}, 8'h01);
    irq_src[0] = 1'b0;
    port_id    = 8'h00;
    ack();
    check("t1_irq_after_ack", {7'b0, interrupt}, 8'h00);
    chk_reg("t1_vector", 8'd2, 8'h80);
    chk_reg("t1_pending", 8'd0, 8'h00);
    bus_write(8'd2, 8'h00);
    chk_reg("t1_vector_eoi", 8'd2, 8'h00);

    // Two simultaneous sources: priority, then re-assert after EOI.
    bus_write(8'd1, 8'hFF);
    pulse(8'h24);
    wait_irq("t2_irq1", 1'b1, 10);
    ack();
    chk_reg("t2_vector1", 8'd2, 8'h82);
    bus_write(8'd2, 8'h00);
    wait_irq("t2_irq2", 1'b1, 10);
    ack();
    chk_reg("t2_vector2", 8'd2, 8'h85);
    bus_write(8'd2, 8'h00);
    chk_reg("t2_pending", 8'd0, 8'h00);
    chk_reg("t2_vector_eoi", 8'd2, 8'h05);

    // Masked pending, unmask, then withdraw by W1C before ack.
    bus_write(8'd1, 8'h00);
    pulse(8'h04);
    repeat (4) @(negedge clk);
    check("t3_irq_masked", {7'b0, interrupt}, 8'h00);
    chk_reg("t3_pending", 8'd0, 8'h04);
    bus_write(8'd1, 8'h04);
    wait_irq("t3_irq_unmask", 1'b1, 8);
    bus_write(8'd0, 8'h04);
    wait_irq("t3_irq_drop", 1'b0, 6);
    chk_reg("t3_pending_clr", 8'd0, 8'h00);
    ack();
    chk_reg("t3_vector_stray_ack", 8'd2, 8'h05);

    // W1C and a new edge on the same bit in the same cycle; level-high sets nothing.
    bus_write(8'd1, 8'h00);
    @(negedge clk);
    irq_src[3] = 1'b1;
    repeat (2) @(negedge clk);
    port_id      = BASE;
    out_port     = 8'h08;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
    port_id      = 8'h00;
    chk_reg("t4_set_wins", 8'd0, 8'h08);
    bus_write(8'd0, 8'h08);
    repeat (3) @(negedge clk);
    chk_reg("t4_level_no_set", 8'd0, 8'h00);
    irq_src[3] = 1'b0;
    repeat (4) @(negedge clk);

    // Read path decode and register widths.
    bus_write(8'd1, 8'hA5);
    bus_read(8'd1, rdv, rdh);
    check("t6_hit", {7'b0, rdh}, 8'h01);
    check("t6_mask", rdv, 8'hA5);
    bus_read(8'd4, rdv, rdh);
    check("t6_miss", {7'b0, rdh}, 8'h00);
    bus_write(8'd3, 8'hFF);
    chk_reg("t6_ctrl_bit0", 8'd3, 8'h01);

    // Asynchronous reset in the middle of ASSERT.
    bus_write(8'd1, 8'h01);
    pulse(8'h01);
    wait_irq("t5_irq", 1'b1, 8);
    @(negedge clk);
    port_id = BASE + 8'd1;
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("t5_irq_async", {7'b0, interrupt}, 8'h00);
    check("t5_hit_async", {7'b0, rd_hit}, 8'h00);
    check("t5_rdata_async", rd_data, 8'h00);
    #1 reset_n = 1'b1;
    port_id = 8'h00;
    chk_reg("t5_pending", 8'd0, 8'h00);
    chk_reg("t5_mask", 8'd1, 8'h00);
    chk_reg("t5_vector", 8'd2, 8'h00);
    chk_reg("t5_ctrl", 8'd3, 8'h00);

    // Randomized transactions against the register/handshake model.
    m_pend = '0;
    m_mask = '0;
    m_en   = 1'b1;
    bus_write(8'd3, 8'h01);
    for (int it = 0; it < 40; it++) begin
      ev = 8'($urandom);
      if ($urandom_range(0, 2) == 0) ev = '0;
      if (ev != 0) begin
        pulse(ev);
        m_pend = m_pend | ev;
      end
      if ($urandom_range(0, 1) == 1) begin
        m_mask = 8'($urandom);
        bus_write(8'd1, m_mask);
      end
      m_en = ($urandom_range(0, 4) != 0);
      bus_write(8'd3, {7'b0, m_en});
      chk_reg("rnd_pending", 8'd0, m_pend);
      chk_reg("rnd_mask", 8'd1, m_mask);
      act = m_pend & m_mask;
      if (m_en && act != 0) begin
        wait_irq("rnd_irq", 1'b1, 8);
        ack();
        idx    = $clog2(act & (~act + 8'd1));
        m_pend = m_pend & ~(8'b1 << idx);
        chk_reg("rnd_vector", 8'd2, 8'h80 | 8'(idx));
        w = 8'($urandom) & 8'($urandom);
        if (w != 0) begin
          bus_write(8'd0, w);
          m_pend = m_pend & ~w;
        end
        bus_write(8'd2, 8'h00);
        chk_reg("rnd_vector_eoi", 8'd2, 8'(idx));
      end else begin
        repeat (4) @(negedge clk);
        check("rnd_quiet", {7'b0, interrupt}, 8'h00);
      end
    end
    chk_reg("rnd_final_pending", 8'd0, m_pend);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
